// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP/IPv4 transmit path.
// Optional short-frame padding is enabled by UDP_TX_PAD_EN.
package udp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_CSUM,
    ST_FOLD,
    ST_HDR,
    ST_PAY,
    ST_PAD,
    ST_GAP
  } t_tx_st;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam int          HDR_WORDS     = 11;
  localparam int          MIN_PAY       = 18;
  localparam int          PAD_WORDS     = (MIN_PAY + 3) / 4;

  function automatic logic [15:0] words_of(
    input logic [15:0] n
  );
    logic [16:0] t;
    t = {1'b0, n} + 17'd3;
    return 16'(t >> 2);
  endfunction

endpackage

// File: rtl/ip_csum.sv
// Serial 16-bit one's-complement accumulator for the IPv4 header.
// Twenty-bit sum leaves room for ten adds; two folds then close it.
module ip_csum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] din,
  output logic [15:0] csum
);

  logic [19:0] acc;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + {4'h0, din};
    end else if (fold) begin
      acc <= {4'h0, acc[15:0]} + {16'h0, acc[19:16]};
    end
  end

  assign csum = ~acc[15:0];

endmodule

// File: rtl/udp_send.sv
// UDP/IPv4 frame transmitter feeding a shift16 MAC TX FIFO.
// Define UDP_TX_PAD_EN to zero-pad short frames to minimum size.
module udp_send
  import udp_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1472,
  parameter int IP_TTL      = 64,
  parameter int IFG_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] desc_q,
  input  logic        desc_empty,
  output logic        desc_rdreq,
  input  logic [31:0] data_q,
  input  logic        data_empty,
  output logic        data_rdreq,
  input  logic [47:0] my_mac,
  input  logic [47:0] dst_mac,
  input  logic [31:0] my_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] my_port,
  input  logic [15:0] dst_port,
  output logic [31:0] tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        tx_wren,
  output logic [1:0]  tx_mod,
  output logic        tx_err,
  input  logic        tx_rdy,
  output logic        busy,
  output logic        frm_sent,
  output logic        drop
);

  t_tx_st st, nxt;

  logic [15:0] cnt, cnt_nxt;
  logic [15:0] len, ip_id;
  logic [47:0] dmac_r, smac_r;
  logic [31:0] sip_r, dip_r;
  logic [15:0] sport_r, dport_r;

  logic        cs_clr, cs_add, cs_fold;
  logic [15:0] cs_din, csum;

  logic [15:0] pay_w, tot_w;
  logic [15:0] ip_len, udp_len;
  logic [1:0]  eop_mod;
  logic        bad, acc;
  logic [31:0] hdr_word, pay_word, last_mask;

  ip_csum u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (cs_clr),
    .add  (cs_add),
    .fold (cs_fold),
    .din  (cs_din),
    .csum (csum)
  );

  assign pay_w   = words_of(len);
  assign bad     = (len == 16'd0) ||
                   ({16'd0, len} > 32'(MAX_PAYLOAD));
  assign ip_len  = 16'd28 + len;
  assign udp_len = 16'd8 + len;
  assign acc     = tx_wren & tx_rdy;
  assign busy    = (st != ST_IDLE);
  assign tx_err  = 1'b0;

`ifdef UDP_TX_PAD_EN
  logic short_f;
  assign short_f = len < 16'(MIN_PAY);
  assign tot_w   = short_f ? 16'(PAD_WORDS) : pay_w;
  assign eop_mod = short_f ? 2'd2 :
                   2'(3'd4 - {1'b0, len[1:0]});
`else
  assign tot_w   = pay_w;
  assign eop_mod = 2'(3'd4 - {1'b0, len[1:0]});
`endif

  always_comb begin
    last_mask = 32'hFFFF_FFFF;
    unique case (len[1:0])
      2'd1:    last_mask = 32'hFF00_0000;
      2'd2:    last_mask = 32'hFFFF_0000;
      2'd3:    last_mask = 32'hFFFF_FF00;
      default: last_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Bytes past L in the final payload word go out as zero.
  assign pay_word = (cnt == pay_w - 16'd1) ?
                    (data_q & last_mask) : data_q;

  always_comb begin
    cs_din = 16'h0000;
    case (cnt[3:0])
      4'd0: cs_din = 16'h4500;
      4'd1: cs_din = ip_len;
      4'd2: cs_din = ip_id;
      4'd3: cs_din = 16'h4000;
      4'd4: cs_din = {8'(IP_TTL), IP_PROTO_UDP};
      4'd6: cs_din = sip_r[31:16];
      4'd7: cs_din = sip_r[15:0];
      4'd8: cs_din = dip_r[31:16];
      4'd9: cs_din = dip_r[15:0];
      default: cs_din = 16'h0000;
    endcase
  end

  always_comb begin
    hdr_word = 32'h0;
    case (cnt)
      16'd0:  hdr_word = {16'h0, dmac_r[47:32]};
      16'd1:  hdr_word = dmac_r[31:0];
      16'd2:  hdr_word = smac_r[47:16];
      16'd3:  hdr_word = {smac_r[15:0], ETH_TYPE_IPV4};
      16'd4:  hdr_word = {16'h4500, ip_len};
      16'd5:  hdr_word = {ip_id, 16'h4000};
      16'd6:  hdr_word = {8'(IP_TTL), IP_PROTO_UDP, csum};
      16'd7:  hdr_word = sip_r;
      16'd8:  hdr_word = dip_r;
      16'd9:  hdr_word = {sport_r, dport_r};
      16'd10: hdr_word = {udp_len, 16'h0};
      default: hdr_word = 32'h0;
    endcase
  end

  always_comb begin
    nxt        = st;
    cnt_nxt    = cnt;
    desc_rdreq = 1'b0;
    data_rdreq = 1'b0;
    tx_wren    = 1'b0;
    tx_sop     = 1'b0;
    tx_eop     = 1'b0;
    tx_mod     = 2'd0;
    tx_data    = 32'h0;
    cs_clr     = 1'b0;
    cs_add     = 1'b0;
    cs_fold    = 1'b0;
    unique case (st)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!desc_empty) begin
          desc_rdreq = 1'b1;
          nxt        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cs_clr  = 1'b1;
        cnt_nxt = '0;
        nxt     = bad ? ST_DRAIN : ST_CSUM;
      end
      ST_DRAIN: begin
        if (cnt == pay_w) begin
          nxt     = ST_IDLE;
          cnt_nxt = '0;
        end else if (!data_empty) begin
          data_rdreq = 1'b1;
          cnt_nxt    = cnt + 16'd1;
        end
      end
      ST_CSUM: begin
        cs_add  = 1'b1;
        cnt_nxt = cnt + 16'd1;
        if (cnt == 16'd9) begin
          nxt     = ST_FOLD;
          cnt_nxt = '0;
        end
      end
      ST_FOLD: begin
        cs_fold = 1'b1;
        cnt_nxt = cnt + 16'd1;
        if (cnt == 16'd1) begin
          nxt     = ST_HDR;
          cnt_nxt = '0;
        end
      end
      ST_HDR: begin
        tx_wren = 1'b1;
        tx_sop  = (cnt == 16'd0);
        tx_data = hdr_word;
        if (tx_rdy) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == 16'(HDR_WORDS - 1)) begin
            nxt     = ST_PAY;
            cnt_nxt = '0;
          end
        end
      end
      ST_PAY: begin
        tx_wren    = !data_empty;
        tx_data    = pay_word;
        tx_eop     = (cnt == tot_w - 16'd1);
        tx_mod     = tx_eop ? eop_mod : 2'd0;
        data_rdreq = !data_empty && tx_rdy;
        if (!data_empty && tx_rdy) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == tot_w - 16'd1) begin
            nxt     = ST_GAP;
            cnt_nxt = '0;
`ifdef UDP_TX_PAD_EN
          end else if (cnt == pay_w - 16'd1) begin
            nxt = ST_PAD;
`endif
          end
        end
      end
`ifdef UDP_TX_PAD_EN
      ST_PAD: begin
        tx_wren = 1'b1;
        tx_eop  = (cnt == tot_w - 16'd1);
        tx_mod  = tx_eop ? eop_mod : 2'd0;
        if (tx_rdy) begin
          cnt_nxt = cnt + 16'd1;
          if (tx_eop) begin
            nxt     = ST_GAP;
            cnt_nxt = '0;
          end
        end
      end
`endif
      ST_GAP: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == 16'(IFG_CYC - 1)) begin
          nxt     = ST_IDLE;
          cnt_nxt = '0;
        end
      end
      default: begin
        nxt     = ST_IDLE;
        cnt_nxt = '0;
      end
    endcase
    // No FIFO pops while reset is held.
    if (rst) begin
      desc_rdreq = 1'b0;
      data_rdreq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      len      <= '0;
      ip_id    <= '0;
      frm_sent <= 1'b0;
      drop     <= 1'b0;
      dmac_r   <= '0;
      smac_r   <= '0;
      sip_r    <= '0;
      dip_r    <= '0;
      sport_r  <= '0;
      dport_r  <= '0;
    end else begin
      st       <= nxt;
      cnt      <= cnt_nxt;
      frm_sent <= acc & tx_eop;
      drop     <= (st == ST_DRAIN) && (cnt == pay_w);
      if (desc_rdreq) len <= desc_q;
      if (acc & tx_eop) ip_id <= ip_id + 16'd1;
      if (st == ST_LOAD) begin
        dmac_r  <= dst_mac;
        smac_r  <= my_mac;
        sip_r   <= my_ip;
        dip_r   <= dst_ip;
        sport_r <= my_port;
        dport_r <= dst_port;
      end
    end
  end

endmodule
